// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: FSM state encodings and default widths for the RAM burst reader
package ram_stream_reader_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int LW_DEF = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/ram_stream_reader_fifo.sv
// stream_fifo2: 2-entry valid/ready FIFO with registered head
//   in_valid/in_ready/in_data   : push side (push accepted when full if a pop happens too)
//   out_valid/out_ready/out_data: pop side, out_data is the head register
//   count                       : current occupancy 0..2
module stream_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic push, pop, load_head;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = head_q;
  assign count     = cnt_q;
  assign pop       = out_valid & out_ready;
  assign in_ready  = (cnt_q != 2'd2) | out_ready;
  assign push      = in_valid & in_ready;
  // Head reloads when it empties-then-refills or is popped with a successor available.
  assign load_head = (pop & ((cnt_q == 2'd2) | push)) | (push & (cnt_q == 2'd0));
  always_comb begin
    head_d = load_head ? ((pop & (cnt_q == 2'd2)) ? tail_q : in_data) : head_q;
    tail_d = (push & ((cnt_q == 2'd2) | ((cnt_q == 2'd1) & !pop))) ? in_data : tail_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader walking len words from base into a valid/ready stream
//   start/base/len : burst request (sampled in IDLE), first address, word count (0 = empty)
//   busy/done      : burst in progress / one-cycle completion pulse
//   raddr/rdata    : combinational-read RAM port
//   out_valid/out_ready/out_data/out_last : output stream, last tags the final word
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);
  logic [1:0] state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic empty_q, empty_d;
  logic f_in_ready, f_valid, fetch, pop, drained, last_word;
  logic [1:0] f_cnt;
  logic [DW:0] f_data;
  assign last_word = rem_q == LW'(1);
  assign fetch     = (state_q == S_RUN) & f_in_ready;
  assign pop       = f_valid & out_ready;
  // FIFO is empty after this edge, counting a pop of the final word this cycle.
  assign drained   = (f_cnt == 2'd0) | ((f_cnt == 2'd1) & pop);
  stream_fifo2 #(.W(DW + 1)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fetch),
    .in_ready (f_in_ready),
    .in_data  ({last_word, rdata}),
    .out_valid(f_valid),
    .out_ready(out_ready),
    .out_data (f_data),
    .count    (f_cnt)
  );
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rem_d   = rem_q;
    empty_d = empty_q;
    case (state_q)
      S_IDLE: if (start) begin
        raddr_d = base;
        rem_d   = len;
        empty_d = len == '0;
        state_d = (len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: if (fetch) begin
        raddr_d = raddr_q + AW'(1);
        rem_d   = rem_q - LW'(1);
        state_d = last_word ? S_DRAIN : S_RUN;
      end
      S_DRAIN: state_d = drained ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      rem_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rem_q   <= rem_d;
      empty_q <= empty_d;
    end
  end
  assign raddr     = raddr_q;
  assign done      = state_q == S_DONE;
  // An empty burst still shows busy for its single DONE cycle.
  assign busy      = (state_q == S_RUN) | (state_q == S_DRAIN) | ((state_q == S_DONE) & empty_q);
  assign out_valid = f_valid;
  assign out_data  = f_data[DW-1:0];
  assign out_last  = f_valid & f_data[DW];
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: table-driven burst checks plus reset corner sequences
module tb_ram_stream_reader;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
  logic [7:0] base = 0, raddr;
  logic [15:0] len = 0, rdata, out_data;
  logic busy, done, out_valid, out_last;
  int checks = 0, fails = 0;
  ram_stream_reader #(.AW(8), .DW(16), .LW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );
  assign rdata = 16'hA000 + {8'h00, raddr};
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0]  b;
    logic [15:0] l;
    logic [15:0] pat;
    int          exp_done;
    bit          mid;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_last"}, {31'd0, out_last}, 0);
    chk({tag, "_data"}, {16'd0, out_data}, 0);
    chk({tag, "_raddr"}, {24'd0, raddr}, 0);
  endtask
  task automatic run_burst(input vec_t v);
    int cnt = 0, done_cyc = -1, lead;
    bit prev_stall = 0;
    logic [15:0] prev_data = 0;
    logic [7:0] a;
    @(negedge clk);
    start = 1; base = v.b; len = v.l;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = v.pat[cyc % 16];
      if (v.mid) begin
        start = (cyc == 2);
        if (cyc == 2) begin base = 8'h40; len = 16'd3; end
      end
      if (cyc == 0) chk("busy_after_start", {31'd0, busy}, 1);
      lead = int'(8'(raddr - v.b)) - cnt;
      chk("raddr_lead", {31'd0, (lead >= 0 && lead <= 2)}, 1);
      if (prev_stall) chk("stall_hold", {16'd0, out_data}, {16'd0, prev_data});
      if (done) begin
        chk("valid_at_done", {31'd0, out_valid}, 0);
        done_cyc = cyc;
        break;
      end
      if (out_valid && out_ready) begin
        a = v.b + 8'(cnt);
        chk("data", {16'd0, out_data}, {16'd0, 16'hA000 + {8'h00, a}});
        chk("last", {31'd0, out_last}, {31'd0, (cnt == int'(v.l) - 1)});
        cnt++;
      end
      prev_stall = out_valid & !out_ready;
      prev_data = out_data;
    end
    start = 0;
    out_ready = 1;
    chk("done_seen", {31'd0, done_cyc >= 0}, 1);
    if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
    chk("word_count", cnt, {16'd0, v.l});
    chk("raddr_end", {24'd0, raddr}, {24'd0, v.b + v.l[7:0]});
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 0);
    chk("busy_after", {31'd0, busy}, 0);
  endtask
  vec_t vecs[6];
  initial begin
    vecs[0] = '{8'h10, 16'd4, 16'hFFFF, 5, 1'b0};
    vecs[1] = '{8'h20, 16'd6, 16'h9A69, -1, 1'b0};
    vecs[2] = '{8'hFE, 16'd4, 16'hFFFF, 5, 1'b0};
    vecs[3] = '{8'h33, 16'd0, 16'hFFFF, 0, 1'b0};
    vecs[4] = '{8'h50, 16'd5, 16'hFFFF, 6, 1'b1};
    vecs[5] = '{8'h07, 16'd1, 16'hFFFF, 2, 1'b0};
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) run_burst(vecs[i]);
    @(negedge clk);
    start = 1; base = 8'h30; len = 16'd5;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("rst_seq_w0", {16'd0, out_data}, 32'h0000A030);
    @(negedge clk);
    chk("rst_seq_w1", {16'd0, out_data}, 32'h0000A031);
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, done}, 0);
    end
    rst_n = 1;
    run_burst('{8'h00, 16'd2, 16'hFFFF, 3, 1'b0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
